// File: rtl/cvmcu_cpi_tx.sv
`default_nettype none
// ============================================================================
// Module   : cvmcu_cpi_tx
// Purpose  : Camera-side CPI transmitter. Converts a valid/ready pixel stream
//            into framed CPI traffic (cam_data/cam_hsync/cam_vsync) with
//            programmable geometry and blanking, single or continuous frames.
// Ports    : clk_i, rst_i           clock, synchronous active-high reset
//            start_i, stop_i        frame start request / end continuous run
//            cfg_*_i                frame geometry, latched on accepted start
//            pix_data_i/valid_i     pixel source; pix_ready_o = taken this cycle
//            cam_data_o/hsync_o/vsync_o  registered CPI pins
//            busy_o, frame_done_o, underrun_o  status
// Revision : 1.0 - initial release
// ============================================================================
module cvmcu_cpi_tx #(
  parameter int DATA_WIDTH = 16,
  parameter int DIM_WIDTH  = 12
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  cfg_cont_i,
  input  logic [DIM_WIDTH-1:0]  cfg_width_i,
  input  logic [DIM_WIDTH-1:0]  cfg_height_i,
  input  logic [DIM_WIDTH-1:0]  cfg_hblank_i,
  input  logic [DIM_WIDTH-1:0]  cfg_vblank_i,
  input  logic [DIM_WIDTH-1:0]  cfg_vsync_len_i,
  input  logic [DATA_WIDTH-1:0] pix_data_i,
  input  logic                  pix_valid_i,
  output logic                  pix_ready_o,
  output logic [DATA_WIDTH-1:0] cam_data_o,
  output logic                  cam_hsync_o,
  output logic                  cam_vsync_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  underrun_o
);

  localparam logic [DIM_WIDTH-1:0] ONE = DIM_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_VSYNC  = 3'd1,
    S_HBLANK = 3'd2,
    S_LINE   = 3'd3,
    S_VBLANK = 3'd4,
    S_END    = 3'd5
  } state_t;

  state_t state, state_next;

  // Shadow copies of the configuration, frozen for the whole run
  logic [DIM_WIDTH-1:0] width_q, height_q, hblank_q, vblank_q, vsync_len_q;
  logic                 cont_q;

  logic [DIM_WIDTH-1:0] blank_cnt, col_cnt, row_cnt;
  logic                 stop_req;

  logic start_ok;
  logic line_end;
  logic last_row;
  logic transfer;

  assign busy_o      = (state != S_IDLE);
  assign pix_ready_o = (state == S_LINE);
  assign transfer    = pix_valid_i & pix_ready_o;

  always_comb begin
    state_next = state;
    start_ok   = 1'b0;
    line_end   = (col_cnt == width_q - ONE);
    last_row   = (row_cnt == height_q - ONE);
    case (state)
      S_IDLE: begin
        if (start_i && (cfg_width_i != '0) && (cfg_height_i != '0)) begin
          start_ok   = 1'b1;
          state_next = S_VSYNC;
        end
      end
      S_VSYNC: begin
        if (blank_cnt == vsync_len_q - ONE)
          state_next = (hblank_q == '0) ? S_LINE : S_HBLANK;
      end
      S_HBLANK: begin
        if (blank_cnt == hblank_q - ONE)
          state_next = S_LINE;
      end
      S_LINE: begin
        if (line_end) begin
          if (last_row)
            state_next = (vblank_q == '0) ? S_END : S_VBLANK;
          else
            state_next = (hblank_q == '0) ? S_LINE : S_HBLANK;
        end
      end
      S_VBLANK: begin
        if (blank_cnt == vblank_q - ONE)
          state_next = S_END;
      end
      S_END: begin
        // A stop arriving in the END cycle itself still ends the run
        state_next = (cont_q && !stop_req && !stop_i) ? S_VSYNC : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= S_IDLE;
      cam_data_o   <= '0;
      cam_hsync_o  <= 1'b0;
      cam_vsync_o  <= 1'b0;
      frame_done_o <= 1'b0;
      underrun_o   <= 1'b0;
      stop_req     <= 1'b0;
      blank_cnt    <= '0;
      col_cnt      <= '0;
      row_cnt      <= '0;
      width_q      <= '0;
      height_q     <= '0;
      hblank_q     <= '0;
      vblank_q     <= '0;
      vsync_len_q  <= ONE;
      cont_q       <= 1'b0;
    end else begin
      state <= state_next;

      // Pins trail the state by one cycle
      cam_vsync_o  <= (state == S_VSYNC);
      cam_hsync_o  <= (state == S_LINE);
      cam_data_o   <= transfer ? pix_data_i : '0;
      frame_done_o <= (state == S_END);

      if (start_ok) begin
        width_q     <= cfg_width_i;
        height_q    <= cfg_height_i;
        hblank_q    <= cfg_hblank_i;
        vblank_q    <= cfg_vblank_i;
        vsync_len_q <= (cfg_vsync_len_i == '0) ? ONE : cfg_vsync_len_i;
        cont_q      <= cfg_cont_i;
        underrun_o  <= 1'b0;
      end else if ((state == S_LINE) && !pix_valid_i) begin
        underrun_o  <= 1'b1;
      end

      if (state == S_IDLE)
        stop_req <= 1'b0;
      else if (stop_i)
        stop_req <= 1'b1;

      // Blank counter restarts on every phase change; it serves all blank states
      if (state_next != state)
        blank_cnt <= '0;
      else if ((state == S_VSYNC) || (state == S_HBLANK) || (state == S_VBLANK))
        blank_cnt <= blank_cnt + ONE;

      if (state == S_LINE)
        col_cnt <= line_end ? '0 : col_cnt + ONE;
      else
        col_cnt <= '0;

      if (state == S_VSYNC)
        row_cnt <= '0;
      else if ((state == S_LINE) && line_end)
        row_cnt <= row_cnt + ONE;
    end
  end

endmodule
`default_nettype wire
